// File: rtl/serial_sample_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the serial sample loader:
//   - loader_state_e : frame-loading FSM states
//   - ERR_*          : codes reported on oError
//   - F_*            : field order inside one sample (input, expected, valid)
// ---------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    LOAD   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } loader_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_COUNT   = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [1:0] F_IN  = 2'd0;
  localparam logic [1:0] F_EXP = 2'd1;
  localparam logic [1:0] F_VAL = 2'd2;

endpackage

// File: rtl/serial_sample_loader_timeout.sv
// ---------------------------------------------------------------------------
// byte_timeout_counter
// Counts idle cycles while the loader is waiting for bytes.
//   clk_i     : system clock
//   rst_i     : synchronous active-high reset
//   clear_i   : restart the count (byte accepted, or loader not busy)
//   enable_i  : loader is in a byte-accepting state
//   expired_o : TIMEOUT_CYCLES idle cycles have elapsed (this cycle is the
//               last one); never asserted when TIMEOUT_CYCLES is 0
// ---------------------------------------------------------------------------
module byte_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);
  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of idle cycles already completed, so reaching
  // LIMIT means the current cycle is idle cycle number TIMEOUT_CYCLES.
  assign expired_o = ENABLED && enable_i && (cnt_q == LIMIT_C);

endmodule

// File: rtl/serial_sample_loader.sv
// ---------------------------------------------------------------------------
// serial_sample_loader
// Assembles NUM_SAMPLES-deep tables of input / expected / valid-mask vectors
// from a framed serial byte stream: COUNT, N samples, CHK (XOR of all
// preceding bytes). Tables are published after a clean frame (oDone) or the
// failure reason is reported on oError.
// Ports:
//   iClock, iReset      : clock, synchronous active-high reset
//   iStart              : begin a new frame (IDLE only)
//   iByte, iByteValid   : byte stream input
//   oByteReady          : byte accepted when iByteValid & oByteReady
//   iAck                : acknowledge DONE / ERROR, return to IDLE
//   oBusy               : HEADER, LOAD or CHECK
//   oDone, oError       : result (0 none, 1 count, 2 checksum, 3 timeout)
//   oSampleCount        : COUNT byte of the current / last frame
//   oInputs, oExpected, oValidMask : tables, entry k at [k*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module serial_sample_loader
  import loader_pkg::*;
#(
  parameter int NUM_SAMPLES    = 32,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic                          iStart,
  input  logic [7:0]                    iByte,
  input  logic                          iByteValid,
  output logic                          oByteReady,
  input  logic                          iAck,
  output logic                          oBusy,
  output logic                          oDone,
  output logic [1:0]                    oError,
  output logic [7:0]                    oSampleCount,
  output logic [NUM_SAMPLES*DATA_W-1:0] oInputs,
  output logic [NUM_SAMPLES*DATA_W-1:0] oExpected,
  output logic [NUM_SAMPLES*DATA_W-1:0] oValidMask
);

  localparam int TBL_W = NUM_SAMPLES * DATA_W;
  localparam int BPF   = DATA_W / 8;
  localparam int BIW   = (BPF > 1) ? $clog2(BPF) : 1;
  localparam logic [BIW-1:0] LAST_BYTE_C = BIW'(BPF - 1);
  localparam logic [8:0]     MAX_COUNT_C = 9'(NUM_SAMPLES);

  loader_state_e    state_q,    state_d;
  logic [TBL_W-1:0] inputs_q,   inputs_d;
  logic [TBL_W-1:0] expected_q, expected_d;
  logic [TBL_W-1:0] valid_q,    valid_d;
  logic [7:0]       count_q,    count_d;
  logic [1:0]       error_q,    error_d;
  logic             done_q,     done_d;
  logic [7:0]       chk_q,      chk_d;
  logic [BIW-1:0]   byte_idx_q, byte_idx_d;
  logic [1:0]       field_q,    field_d;
  logic [7:0]       sample_q,   sample_d;

  logic byte_ready_s;
  logic busy_s;
  logic accept_s;
  logic expired_s;
  logic last_byte_s;
  int   lane_pos_s;

  assign busy_s       = (state_q == HEADER) || (state_q == LOAD) || (state_q == CHECK);
  assign byte_ready_s = busy_s;
  assign accept_s     = iByteValid && byte_ready_s;

  // The idle counter restarts on every accepted byte and whenever the loader
  // is outside the busy states, so entry from IDLE always starts from zero.
  byte_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (iClock),
    .rst_i     (iReset),
    .clear_i   (accept_s || !busy_s),
    .enable_i  (busy_s),
    .expired_o (expired_s)
  );

  // Bit position of the byte lane currently being loaded.
  always_comb begin
    lane_pos_s = int'(sample_q) * DATA_W + int'(byte_idx_q) * 8;
  end

  // Current byte is the last byte of the valid field of sample N-1.
  always_comb begin
    last_byte_s = 1'b0;
    if ((byte_idx_q == LAST_BYTE_C) && (field_q == F_VAL) &&
        (sample_q == (count_q - 8'd1))) begin
      last_byte_s = 1'b1;
    end else begin
      last_byte_s = 1'b0;
    end
  end

  // Frame FSM and table / counter next-state logic.
  always_comb begin
    state_d    = state_q;
    inputs_d   = inputs_q;
    expected_d = expected_q;
    valid_d    = valid_q;
    count_d    = count_q;
    error_d    = error_q;
    done_d     = done_q;
    chk_d      = chk_q;
    byte_idx_d = byte_idx_q;
    field_d    = field_q;
    sample_d   = sample_q;

    case (state_q)
      IDLE: begin
        if (iStart) begin
          inputs_d   = '0;
          expected_d = '0;
          valid_d    = '0;
          count_d    = 8'd0;
          error_d    = ERR_NONE;
          done_d     = 1'b0;
          chk_d      = 8'd0;
          byte_idx_d = '0;
          field_d    = F_IN;
          sample_d   = 8'd0;
          state_d    = HEADER;
        end else begin
          state_d = IDLE;
        end
      end

      HEADER: begin
        if (accept_s) begin
          chk_d   = chk_q ^ iByte;
          count_d = iByte;
          if ((iByte == 8'd0) || ({1'b0, iByte} > MAX_COUNT_C)) begin
            error_d = ERR_COUNT;
            state_d = ERROR;
          end else begin
            state_d = LOAD;
          end
        end else if (expired_s) begin
          error_d = ERR_TIMEOUT;
          state_d = ERROR;
        end else begin
          state_d = HEADER;
        end
      end

      LOAD: begin
        if (accept_s) begin
          chk_d = chk_q ^ iByte;
          case (field_q)
            F_IN:    inputs_d[lane_pos_s +: 8]   = iByte;
            F_EXP:   expected_d[lane_pos_s +: 8] = iByte;
            F_VAL:   valid_d[lane_pos_s +: 8]    = iByte;
            default: inputs_d                    = inputs_q;
          endcase
          // Advance byte lane first, then field, then sample.
          if (byte_idx_q == LAST_BYTE_C) begin
            byte_idx_d = '0;
            if (field_q == F_VAL) begin
              field_d  = F_IN;
              sample_d = sample_q + 8'd1;
            end else begin
              field_d = field_q + 2'd1;
            end
          end else begin
            byte_idx_d = byte_idx_q + {{(BIW-1){1'b0}}, 1'b1};
          end
          if (last_byte_s) begin
            state_d = CHECK;
          end else begin
            state_d = LOAD;
          end
        end else if (expired_s) begin
          error_d = ERR_TIMEOUT;
          state_d = ERROR;
        end else begin
          state_d = LOAD;
        end
      end

      CHECK: begin
        if (accept_s) begin
          if (iByte == chk_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            error_d = ERR_CHK;
            state_d = ERROR;
          end
        end else if (expired_s) begin
          error_d = ERR_TIMEOUT;
          state_d = ERROR;
        end else begin
          state_d = CHECK;
        end
      end

      DONE, ERROR: begin
        // Tables and count stay visible after acknowledge.
        if (iAck) begin
          done_d  = 1'b0;
          error_d = ERR_NONE;
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, tables and status registers.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q    <= IDLE;
      inputs_q   <= '0;
      expected_q <= '0;
      valid_q    <= '0;
      count_q    <= 8'd0;
      error_q    <= ERR_NONE;
      done_q     <= 1'b0;
      chk_q      <= 8'd0;
      byte_idx_q <= '0;
      field_q    <= F_IN;
      sample_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      inputs_q   <= inputs_d;
      expected_q <= expected_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      error_q    <= error_d;
      done_q     <= done_d;
      chk_q      <= chk_d;
      byte_idx_q <= byte_idx_d;
      field_q    <= field_d;
      sample_q   <= sample_d;
    end
  end

  assign oByteReady   = byte_ready_s;
  assign oBusy        = busy_s;
  assign oDone        = done_q;
  assign oError       = error_q;
  assign oSampleCount = count_q;
  assign oInputs      = inputs_q;
  assign oExpected    = expected_q;
  assign oValidMask   = valid_q;

endmodule

// File: tb/tb_serial_sample_loader.sv
// ---------------------------------------------------------------------------
// tb_serial_sample_loader
// Directed bench. Two loaders share the stimulus: u_dut8 (4 samples x 8 bit)
// and u_dut16 (4 samples x 16 bit), both with a 10-cycle byte timeout. Each
// scenario starts from reset and only checks the instance it targets.
// ---------------------------------------------------------------------------
module tb_serial_sample_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       ack;

  logic        a_ready, a_busy, a_done;
  logic [1:0]  a_err;
  logic [7:0]  a_cnt;
  logic [31:0] a_in, a_exp, a_val;

  logic        b_ready, b_busy, b_done;
  logic [1:0]  b_err;
  logic [7:0]  b_cnt;
  logic [63:0] b_in, b_exp, b_val;

  int checks_cnt;
  int errors_cnt;

  serial_sample_loader #(
    .NUM_SAMPLES    (4),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (10)
  ) u_dut8 (
    .iClock       (clk),
    .iReset       (rst),
    .iStart       (start),
    .iByte        (byte_in),
    .iByteValid   (byte_valid),
    .oByteReady   (a_ready),
    .iAck         (ack),
    .oBusy        (a_busy),
    .oDone        (a_done),
    .oError       (a_err),
    .oSampleCount (a_cnt),
    .oInputs      (a_in),
    .oExpected    (a_exp),
    .oValidMask   (a_val)
  );

  serial_sample_loader #(
    .NUM_SAMPLES    (4),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (10)
  ) u_dut16 (
    .iClock       (clk),
    .iReset       (rst),
    .iStart       (start),
    .iByte        (byte_in),
    .iByteValid   (byte_valid),
    .oByteReady   (b_ready),
    .iAck         (ack),
    .oBusy        (b_busy),
    .oDone        (b_done),
    .oError       (b_err),
    .oSampleCount (b_cnt),
    .oInputs      (b_in),
    .oExpected    (b_exp),
    .oValidMask   (b_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt = checks_cnt + 1;
    if (obs !== exp) begin
      errors_cnt = errors_cnt + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst        = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    ack        = 1'b0;

    // ---------------- reset state ----------------
    do_reset();
    check_val("rst_ready8", {63'd0, a_ready}, 64'd0);
    check_val("rst_busy8",  {63'd0, a_busy},  64'd0);
    check_val("rst_done8",  {63'd0, a_done},  64'd0);
    check_val("rst_err8",   {62'd0, a_err},   64'd0);
    check_val("rst_tbl8",   {32'd0, a_in | a_exp | a_val}, 64'd0);
    check_val("rst_tbl16",  b_in | b_exp | b_val, 64'd0);

    // ---------------- 8-bit frame, N=2 ----------------
    // CHK = 02^01^03^FF^02^00^0F = F2
    do_start();
    check_val("hdr_ready", {63'd0, a_ready}, 64'd1);
    send_byte(8'h02);
    send_byte(8'h01);
    check_val("in0_inplace", {56'd0, a_in[7:0]}, 64'h01);
    send_byte(8'h03);
    send_byte(8'hFF);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h0F);
    check_val("chk_wait_done", {63'd0, a_done}, 64'd0);
    check_val("chk_wait_busy", {63'd0, a_busy}, 64'd1);
    send_byte(8'hF2);
    check_val("f8_done",  {63'd0, a_done},    64'd1);
    check_val("f8_err",   {62'd0, a_err},     64'd0);
    check_val("f8_in",    {48'd0, a_in[15:0]},  64'h0201);
    check_val("f8_exp",   {48'd0, a_exp[15:0]}, 64'h0003);
    check_val("f8_val",   {48'd0, a_val[15:0]}, 64'h0FFF);
    check_val("f8_cnt",   {56'd0, a_cnt},     64'd2);
    check_val("f8_hi0",   {48'd0, a_in[31:16] | a_exp[31:16] | a_val[31:16]}, 64'd0);
    check_val("f8_ready", {63'd0, a_ready},   64'd0);
    // DONE holds without acknowledge
    tick();
    check_val("f8_hold", {63'd0, a_done}, 64'd1);
    do_ack();
    check_val("f8_ack_done", {63'd0, a_done}, 64'd0);
    check_val("f8_ack_keep", {48'd0, a_in[15:0]}, 64'h0201);

    // ---------------- 16-bit frame, N=1 ----------------
    // CHK = 01^34^12^CD^AB^FF^00 = BE
    do_reset();
    do_start();
    send_byte(8'h01);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hCD);
    send_byte(8'hAB);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'hBE);
    check_val("f16_done", {63'd0, b_done}, 64'd1);
    check_val("f16_in",   {48'd0, b_in[15:0]},  64'h1234);
    check_val("f16_exp",  {48'd0, b_exp[15:0]}, 64'hABCD);
    check_val("f16_val",  {48'd0, b_val[15:0]}, 64'h00FF);
    check_val("f16_hi0",  {16'd0, b_in[63:16] | b_exp[63:16] | b_val[63:16]}, 64'd0);

    // ---------------- bad counts ----------------
    do_reset();
    do_start();
    send_byte(8'h05);
    check_val("cnt5_err",   {62'd0, a_err},   64'd1);
    check_val("cnt5_cnt",   {56'd0, a_cnt},   64'd5);
    check_val("cnt5_ready", {63'd0, a_ready}, 64'd0);
    check_val("cnt5_done",  {63'd0, a_done},  64'd0);
    do_ack();
    check_val("cnt5_ack_err", {62'd0, a_err}, 64'd0);
    check_val("cnt5_ack_cnt", {56'd0, a_cnt}, 64'd5);
    do_start();
    send_byte(8'h04);
    check_val("cnt4_ok", {62'd0, a_err}, 64'd0);
    check_val("cnt4_busy", {63'd0, a_busy}, 64'd1);
    do_reset();
    do_start();
    send_byte(8'h00);
    check_val("cnt0_err", {62'd0, a_err}, 64'd1);

    // ---------------- checksum error, ack+start ----------------
    do_reset();
    do_start();
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'hFF);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h0F);
    send_byte(8'hF3);
    check_val("chk_err",  {62'd0, a_err},  64'd2);
    check_val("chk_done", {63'd0, a_done}, 64'd0);
    ack   = 1'b1;
    start = 1'b1;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    check_val("ackstart_err",   {62'd0, a_err},   64'd0);
    check_val("ackstart_ready", {63'd0, a_ready}, 64'd0);
    check_val("ackstart_busy",  {63'd0, a_busy},  64'd0);
    check_val("ackstart_keep",  {48'd0, a_in[15:0]}, 64'h0201);
    do_start();
    check_val("restart_ready", {63'd0, a_ready}, 64'd1);
    check_val("restart_tbl",   {32'd0, a_in | a_exp | a_val}, 64'd0);
    check_val("restart_cnt",   {56'd0, a_cnt}, 64'd0);

    // ---------------- timeout ----------------
    do_reset();
    do_start();
    send_byte(8'h01);
    repeat (9) tick();
    check_val("to_9_err",  {62'd0, a_err},  64'd0);
    check_val("to_9_busy", {63'd0, a_busy}, 64'd1);
    tick();
    check_val("to_10_err",  {62'd0, a_err},  64'd3);
    check_val("to_10_busy", {63'd0, a_busy}, 64'd0);

    // byte accepted in the 10th idle cycle wins; CHK = 01^AA^BB^CC = DC
    do_reset();
    do_start();
    send_byte(8'h01);
    repeat (9) tick();
    send_byte(8'hAA);
    check_val("edge_err", {62'd0, a_err}, 64'd0);
    check_val("edge_in",  {56'd0, a_in[7:0]}, 64'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDC);
    check_val("edge_done", {63'd0, a_done}, 64'd1);

    // ---------------- reset mid-LOAD ----------------
    do_reset();
    do_start();
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h03);
    byte_in    = 8'hAA;
    byte_valid = 1'b1;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mr_ready", {63'd0, a_ready}, 64'd0);
    check_val("mr_busy",  {63'd0, a_busy},  64'd0);
    check_val("mr_done",  {63'd0, a_done},  64'd0);
    check_val("mr_err",   {62'd0, a_err},   64'd0);
    check_val("mr_cnt",   {56'd0, a_cnt},   64'd0);
    check_val("mr_tbl",   {32'd0, a_in | a_exp | a_val}, 64'd0);
    repeat (3) tick();
    check_val("mr_nocap", {32'd0, a_in | a_exp | a_val}, 64'd0);
    check_val("mr_idle",  {63'd0, a_busy}, 64'd0);
    byte_valid = 1'b0;
    do_start();
    check_val("mr_restart", {63'd0, a_ready}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
